data_memory_lsu: RTL and testbench

Parametrised word-organised data memory with a load/store front end for the RV32 core's MEM stage. It supports byte, halfword and word accesses with sign or zero extension, per-byte write strobes, and misaligned and out-of-range error detection. Read latency is configurable and uses a one-outstanding-request valid/ready handshake. It replaces the fixed word-only memory with its combinational read.

---
 rtl/data_memory_lsu.sv | 166 ++++++++++++++++
 tb/tb_data_memory_lsu.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: word-organised data memory with a load/store front end.
// Byte/half/word accesses, per-byte store strobes, sign/zero-extended loads,
// misaligned/out-of-range/illegal-size error detection, and a configurable
// read latency behind a one-outstanding-request valid/ready handshake.
module data_memory_lsu #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] CNT_LAST = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // Request decode (combinational on the live request fields)
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [1:0]        lane;
  logic [3:0]        strb;
  logic [XLEN-1:0]   wdata_rep;
  logic              req_err;
  logic              accept;
  logic              do_store;
  logic              do_load;

  assign word_idx = req_addr[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign lane     = req_addr[1:0];
  assign accept   = req_valid && req_ready;

  // One extra bit on the index so DEPTH == 2^(ADDR_W-2) compares correctly
  assign req_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || ({1'b0, word_idx} >= (ADDR_W - 1)'(DEPTH));

  assign do_store = accept && req_we && !req_err;
  assign do_load  = accept && !req_we && !req_err;

  // Per-lane strobe and replicated store data
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign strb[gi] = (req_size == 2'b00 && lane == 2'(gi))
                   || (req_size == 2'b01 && lane[1] == (gi >= 2))
                   || (req_size == 2'b10);
    assign wdata_rep[8*gi +: 8] = (req_size == 2'b00) ? req_wdata[7:0] :
                                  (req_size == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                                        req_wdata[8*gi +: 8];
  end

  // Memory array (not reset): byte-strobed write and registered read at acceptance
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_word_q;

  // Store commits on the acceptance edge; load word is captured on the same edge
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[mem_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
    if (do_load) rd_word_q <= mem[mem_idx];
  end

  // Captured request attributes needed to shape the response
  logic       we_q, uns_q, err_q;
  logic [1:0] size_q, lane_q;

  // Capture request fields at acceptance so later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      size_q <= 2'b00;
      lane_q <= 2'b00;
    end else if (accept) begin
      we_q   <= req_we;
      uns_q  <= req_unsigned;
      err_q  <= req_err;
      size_q <= req_size;
      lane_q <= lane;
    end
  end

  // FSM state and latency counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a new acceptance in IDLE or RESP restarts the latency count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (RD_LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 3'd0;
          end else begin
            state_d = BUSY;
            cnt_d   = 3'd1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  logic [XLEN-1:0] shifted;
  assign shifted = rd_word_q >> {lane_q, 3'b000};

  // Outputs decoded from registered state and captured data only
  always_comb begin
    logic [XLEN-1:0] load_data;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      2'b10:   load_data = rd_word_q;
      default: load_data = '0;
    endcase
    req_ready = (state_q != BUSY);
    rsp_valid = (state_q == RESP);
    rsp_err   = (state_q == RESP) && err_q;
    rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_data : '0;
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: two instances (latency 1 and 3)
// checked against a byte-addressed behavioural memory model.
module tb_data_memory_lsu;

  localparam int DEPTH = 512;

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit        uns;
    bit [11:0] addr;
    bit [31:0] wdata;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid, req_we, req_unsigned;
  logic [1:0]  req_size  [2];
  logic [11:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  wire  [1:0]  req_ready, rsp_valid, rsp_err;
  wire  [31:0] rsp_rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    data_memory_lsu #(
      .XLEN(32), .ADDR_W(12), .DEPTH(DEPTH), .RD_LATENCY(gi == 0 ? 1 : 3)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[gi]),
      .req_ready    (req_ready[gi]),
      .req_we       (req_we[gi]),
      .req_size     (req_size[gi]),
      .req_unsigned (req_unsigned[gi]),
      .req_addr     (req_addr[gi]),
      .req_wdata    (req_wdata[gi]),
      .rsp_valid    (rsp_valid[gi]),
      .rsp_rdata    (rsp_rdata[gi]),
      .rsp_err      (rsp_err[gi])
    );
  end

  int checks = 0;
  int errors = 0;

  // Byte-addressed reference memory, one per instance
  logic [7:0] mdl [2][DEPTH*4];

  function automatic int lat_of(input bit d);
    return d ? 3 : 1;
  endfunction

  // Reference behaviour: error rules, little-endian byte store, extended load
  function automatic void model(input bit d, input op_t op,
                                output bit [31:0] rd, output bit er);
    int nb;
    bit [31:0] v;
    bit [10:0] ba;
    bit sgn;
    rd = 32'd0;
    er = (op.size == 2'd3) || (op.size == 2'd1 && op.addr[0])
      || (op.size == 2'd2 && op.addr[1:0] != 2'd0) || (int'(op.addr >> 2) >= DEPTH);
    if (er) return;
    nb = 1 << op.size;
    if (op.we) begin
      for (int i = 0; i < nb; i++) begin
        ba = 11'(op.addr + i);
        mdl[d][ba] = op.wdata[8*i +: 8];
      end
      return;
    end
    v = 32'd0;
    for (int i = 0; i < nb; i++) begin
      ba = 11'(op.addr + i);
      v[8*i +: 8] = mdl[d][ba];
    end
    sgn = (op.size == 2'd0) ? v[7] : v[15];
    if (nb < 4 && !op.uns && sgn) v = v | (32'hFFFF_FFFF << (8*nb));
    rd = v;
  endfunction

  function automatic op_t mk(input bit we, input bit [1:0] size, input bit uns,
                             input bit [11:0] addr, input bit [31:0] wdata);
    op_t o;
    o.we = we; o.size = size; o.uns = uns; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  // Drive one request, then scramble the request fields while it is in flight.
  // lat = negedges from acceptance to rsp_valid (-1 if never ready, 0 if no response).
  task automatic issue(input bit d, input op_t op, output bit [31:0] rd, output bit er,
                       output int lat, output bit pulse_ok);
    int n;
    rd = 32'd0; er = 1'b0; lat = 0; pulse_ok = 1'b0;
    @(negedge clk);
    req_we[d] = op.we; req_size[d] = op.size; req_unsigned[d] = op.uns;
    req_addr[d] = op.addr; req_wdata[d] = op.wdata; req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[d] !== 1'b1) begin
      req_valid[d] = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_we[d] = 1'($urandom); req_size[d] = 2'($urandom); req_unsigned[d] = 1'($urandom);
    req_addr[d] = 12'($urandom); req_wdata[d] = $urandom;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid[d] === 1'b1) begin
        lat = k; rd = rsp_rdata[d]; er = rsp_err[d];
      end
    end
    @(negedge clk);
    pulse_ok = (rsp_valid[d] === 1'b0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: got %b want 1", k, req_ready[k]); end
      checks++;
      if (rsp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid dut%0d: got %b want 0", k, rsp_valid[k]); end
      checks++;
      if (rsp_rdata[k] !== 32'd0) begin errors++; $display("FAIL reset_rdata dut%0d: got %h want 0", k, rsp_rdata[k]); end
      checks++;
      if (rsp_err[k] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b want 0", k, rsp_err[k]); end
    end
    $display("reset: outputs sampled after release");
  endtask

  task automatic test_basic();
    op_t ops[$];
    bit [31:0] erd, grd; bit eer, ger, pok; int lat;
    ops = '{mk(1, 2'd2, 0, 12'h010, 32'hDEADBEEF), mk(0, 2'd2, 0, 12'h010, 32'h0)};
    foreach (ops[i]) begin
      model(1'b0, ops[i], erd, eer);
      issue(1'b0, ops[i], grd, ger, lat, pok);
      checks++;
      if (grd !== erd) begin errors++; $display("FAIL basic_rdata #%0d: got %h want %h", i, grd, erd); end
      checks++;
      if (ger !== eer) begin errors++; $display("FAIL basic_err #%0d: got %b want %b", i, ger, eer); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL basic_latency #%0d: got %0d want 1", i, lat); end
      checks++;
      if (!pok) begin errors++; $display("FAIL basic_pulse #%0d: rsp_valid still high, want 0", i); end
      $display("basic dut0 we=%0d size=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
               ops[i].we, ops[i].size, ops[i].addr, ops[i].wdata, grd, ger, lat);
    end
    checks++;
    if (grd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_lw_value: got %h want deadbeef", grd); end
  endtask

  task automatic test_byte_lanes();
    op_t ops[$];
    bit [31:0] erd, grd; bit eer, ger, pok; int lat;
    ops = '{mk(1, 2'd2, 0, 12'h020, 32'h11223344), mk(1, 2'd0, 0, 12'h022, 32'h000000AA),
            mk(0, 2'd2, 0, 12'h020, 32'h0), mk(0, 2'd0, 0, 12'h022, 32'h0),
            mk(0, 2'd0, 1, 12'h022, 32'h0), mk(0, 2'd1, 1, 12'h022, 32'h0),
            mk(1, 2'd1, 0, 12'h026, 32'h0000_8001), mk(0, 2'd1, 0, 12'h026, 32'h0),
            mk(0, 2'd0, 0, 12'h023, 32'h0)};
    foreach (ops[i]) begin
      model(1'b0, ops[i], erd, eer);
      issue(1'b0, ops[i], grd, ger, lat, pok);
      checks++;
      if (grd !== erd) begin errors++; $display("FAIL lanes_rdata #%0d: got %h want %h", i, grd, erd); end
      checks++;
      if (ger !== eer) begin errors++; $display("FAIL lanes_err #%0d: got %b want %b", i, ger, eer); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL lanes_latency #%0d: got %0d want 1", i, lat); end
      $display("lanes dut0 we=%0d size=%0d uns=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d",
               ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, grd, ger);
    end
  endtask

  task automatic test_errors();
    op_t ops[$];
    bit [31:0] erd, grd; bit eer, ger, pok; int lat;
    ops = '{mk(1, 2'd2, 0, 12'h004, 32'hCAFEF00D), mk(0, 2'd1, 0, 12'h001, 32'h0),
            mk(1, 2'd2, 0, 12'h006, 32'h12345678), mk(1, 2'd3, 0, 12'h004, 32'hFFFFFFFF),
            mk(0, 2'd3, 0, 12'h004, 32'h0), mk(0, 2'd2, 0, 12'h004, 32'h0),
            mk(0, 2'd2, 0, 12'h800, 32'h0), mk(1, 2'd0, 0, 12'h804, 32'h55),
            mk(0, 2'd0, 1, 12'hFFF, 32'h0), mk(0, 2'd2, 0, 12'h7FC, 32'h0)};
    // 0x7FC is the last in-range word; write it first so the load is defined
    model(1'b0, mk(1, 2'd2, 0, 12'h7FC, 32'h0BADF00D), erd, eer);
    issue(1'b0, mk(1, 2'd2, 0, 12'h7FC, 32'h0BADF00D), grd, ger, lat, pok);
    foreach (ops[i]) begin
      model(1'b0, ops[i], erd, eer);
      issue(1'b0, ops[i], grd, ger, lat, pok);
      checks++;
      if (grd !== erd) begin errors++; $display("FAIL err_rdata #%0d: got %h want %h", i, grd, erd); end
      checks++;
      if (ger !== eer) begin errors++; $display("FAIL err_flag #%0d: got %b want %b", i, ger, eer); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL err_latency #%0d: got %0d want 1", i, lat); end
      $display("errors dut0 we=%0d size=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d",
               ops[i].we, ops[i].size, ops[i].addr, ops[i].wdata, grd, ger);
    end
  endtask

  task automatic test_back_to_back();
    op_t ld[$];
    bit [31:0] erd, grd; bit eer, ger, pok; int lat;
    bit [31:0] exp_q[$], got_q[$];
    int rsp_c[$];
    int idx, low;
    bit acc;
    for (int i = 0; i < 4; i++) begin
      op_t st;
      st = mk(1, 2'd2, 0, 12'(12'h100 + 4*i), $urandom);
      model(1'b1, st, erd, eer);
      issue(1'b1, st, grd, ger, lat, pok);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL b2b_store_latency #%0d: got %0d want 3", i, lat); end
    end
    ld = '{mk(0, 2'd2, 0, 12'h100, 0), mk(0, 2'd0, 0, 12'h105, 0),
           mk(0, 2'd1, 1, 12'h10A, 0), mk(0, 2'd2, 0, 12'h10C, 0)};
    foreach (ld[i]) begin
      model(1'b1, ld[i], erd, eer);
      exp_q.push_back(erd);
    end
    @(negedge clk);
    idx = 0; low = 0;
    req_we[1] = ld[0].we; req_size[1] = ld[0].size; req_unsigned[1] = ld[0].uns;
    req_addr[1] = ld[0].addr; req_valid[1] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      if (rsp_valid[1] === 1'b1) begin
        rsp_c.push_back(c);
        got_q.push_back(rsp_rdata[1]);
      end
      if (req_ready[1] !== 1'b1) low++;
      acc = (idx < 4) && (req_ready[1] === 1'b1);
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          req_we[1] = ld[idx].we; req_size[1] = ld[idx].size;
          req_unsigned[1] = ld[idx].uns; req_addr[1] = ld[idx].addr;
        end else begin
          req_valid[1] = 1'b0;
        end
      end
    end
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d responses want 4", got_q.size()); end
    checks++;
    if (low != 8) begin errors++; $display("FAIL b2b_ready_low: got %0d low cycles want 8", low); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_rdata #%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      if (i > 0) begin
        checks++;
        if (rsp_c[i] - rsp_c[i-1] != 3) begin
          errors++; $display("FAIL b2b_spacing #%0d: got %0d cycles want 3", i, rsp_c[i] - rsp_c[i-1]);
        end
      end
      $display("b2b dut1 load #%0d addr=%03h -> rdata=%08h at cycle %0d", i, ld[i].addr, got_q[i], rsp_c[i]);
    end
  endtask

  task automatic test_reset_midop();
    op_t st, ld;
    bit [31:0] erd, grd; bit eer, ger, pok; int lat;
    bit seen;
    st = mk(1, 2'd2, 0, 12'h040, 32'h5A5AC3C3);
    ld = mk(0, 2'd2, 0, 12'h040, 32'h0);
    model(1'b1, st, erd, eer);
    issue(1'b1, st, grd, ger, lat, pok);
    @(negedge clk);
    req_we[1] = 1'b0; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
    req_addr[1] = 12'h040; req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL midop_busy: req_ready=%b want 0", req_ready[1]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL midop_ready: req_ready=%b want 1", req_ready[1]); end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midop_dropped: rsp_valid seen=1 want 0"); end
    model(1'b1, ld, erd, eer);
    issue(1'b1, ld, grd, ger, lat, pok);
    checks++;
    if (grd !== erd) begin errors++; $display("FAIL midop_store_kept: got %h want %h", grd, erd); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL midop_latency: got %0d want 3", lat); end
    $display("midop dut1 reset during BUSY, reload addr=040 -> rdata=%08h err=%0d", grd, ger);
  endtask

  task automatic test_random(input bit d);
    op_t op;
    bit [31:0] erd, grd; bit eer, ger, pok; int lat;
    for (int i = 0; i < 32; i++) begin
      op = mk(1, 2'd2, 0, 12'(4*i), $urandom);
      model(d, op, erd, eer);
      issue(d, op, grd, ger, lat, pok);
      checks++;
      if (ger !== 1'b0) begin errors++; $display("FAIL rand_init_err dut%0d #%0d: got %b want 0", d, i, ger); end
    end
    for (int i = 0; i < 80; i++) begin
      op.we    = 1'($urandom);
      op.size  = ($urandom_range(9, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      op.uns   = 1'($urandom);
      op.addr  = ($urandom_range(9, 0) == 0) ? 12'($urandom_range(4095, 2048)) : 12'($urandom_range(127, 0));
      op.wdata = $urandom;
      model(d, op, erd, eer);
      issue(d, op, grd, ger, lat, pok);
      checks++;
      if (grd !== erd) begin errors++; $display("FAIL rand_rdata dut%0d #%0d: got %h want %h", d, i, grd, erd); end
      checks++;
      if (ger !== eer) begin errors++; $display("FAIL rand_err dut%0d #%0d: got %b want %b", d, i, ger, eer); end
      checks++;
      if (lat != lat_of(d)) begin errors++; $display("FAIL rand_latency dut%0d #%0d: got %0d want %0d", d, i, lat, lat_of(d)); end
      checks++;
      if (!pok) begin errors++; $display("FAIL rand_pulse dut%0d #%0d: rsp_valid still high, want 0", d, i); end
      $display("rand dut%0d we=%0d size=%0d uns=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d",
               d, op.we, op.size, op.uns, op.addr, op.wdata, grd, ger);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_unsigned = '0;
    for (int k = 0; k < 2; k++) begin
      req_size[k] = 2'd0; req_addr[k] = 12'd0; req_wdata[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    test_random(1'b0);
    test_random(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
